// File: rtl/pc_pkg.sv
// ============================================================================
// pc_pkg : command priority encoding and sign-extension helper for pc_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

    // Widest operand sext() handles; ADDR_W and OFFS_W must not exceed this.
    localparam int SEXT_W = 32;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_ADV  = 3'd1,
        CMD_REL  = 3'd2,
        CMD_LOAD = 3'd3,
        CMD_CALL = 3'd4,
        CMD_RET  = 3'd5
    } cmd_e;

    // Exactly one command wins per cycle; ret is the most urgent.
    function automatic cmd_e pc_priority(
        input logic ret,
        input logic call,
        input logic load,
        input logic rel,
        input logic adv
    );
        cmd_e c;
        c = CMD_NONE;
        if (ret)       c = CMD_RET;
        else if (call) c = CMD_CALL;
        else if (load) c = CMD_LOAD;
        else if (rel)  c = CMD_REL;
        else if (adv)  c = CMD_ADV;
        return c;
    endfunction

    // Sign-extend the low w bits of v to SEXT_W bits.
    function automatic logic [SEXT_W-1:0] sext(
        input logic [SEXT_W-1:0] v,
        input int                w
    );
        logic signed [SEXT_W-1:0] t;
        t = $signed(v << (SEXT_W - w));
        return $unsigned(t >>> (SEXT_W - w));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ret_stack.sv
// ============================================================================
// pc_ret_stack : LIFO of return addresses; push-on-full / pop-on-empty ignored
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              do_push;
    logic              do_pop;

    assign empty   = (sp == '0);
    assign full    = (sp == SP_FULL);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = IDX_W'(sp);
    assign top_idx = IDX_W'(sp - 1'b1);
    assign dout    = mem[top_idx];

    // Resetting sp alone discards the contents; the storage needs no reset.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + 1'b1;
        end else if (do_pop) begin
            sp <= sp - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : program counter with timed advance, load, relative jump,
//                call/return stack and sticky stack-error flags. Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TICKS_PER_STEP = 2,
    parameter int STACK_DEPTH    = 4,
    parameter int RESET_ADDR     = 0,
    parameter int OFFS_W         = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ldpc,
    input  logic              load,
    input  logic              rel,
    input  logic              call,
    input  logic              ret,
    input  logic              clr_err,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [OFFS_W-1:0] rel_offs,
    output logic [ADDR_W-1:0] abusi,
    output logic              step,
    output logic              stk_empty,
    output logic              stk_full,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(RESET_ADDR);

    cmd_e              cmd;
    logic [TICK_W-1:0] tick;
    logic [ADDR_W-1:0] stk_top;
    logic [ADDR_W-1:0] pc_next_seq;
    logic [ADDR_W-1:0] rel_target;
    logic [SEXT_W-1:0] rel_ext;
    logic              push;
    logic              pop;

    assign cmd         = pc_priority(ret, call, load, rel, ldpc);
    assign pc_next_seq = abusi + 1'b1;
    assign rel_ext     = sext(SEXT_W'(rel_offs), OFFS_W);
    // Truncation to ADDR_W gives the wrap in both directions.
    assign rel_target  = ADDR_W'(SEXT_W'(abusi) + rel_ext);
    assign push        = (cmd == CMD_CALL) && !stk_full;
    assign pop         = (cmd == CMD_RET) && !stk_empty;

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (push),
        .pop     (pop),
        .din     (pc_next_seq),
        .dout    (stk_top),
        .empty   (stk_empty),
        .full    (stk_full)
    );

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            abusi   <= PC_RESET;
            tick    <= '0;
            step    <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            step <= 1'b0;
            // Cleared first so an error event later in this block takes precedence.
            if (clr_err) begin
                err_ovf <= 1'b0;
                err_unf <= 1'b0;
            end
            case (cmd)
                CMD_RET: begin
                    tick <= '0;
                    if (stk_empty) err_unf <= 1'b1;
                    else           abusi   <= stk_top;
                end
                CMD_CALL: begin
                    tick <= '0;
                    if (stk_full) err_ovf <= 1'b1;
                    else          abusi   <= load_addr;
                end
                CMD_LOAD: begin
                    tick  <= '0;
                    abusi <= load_addr;
                end
                CMD_REL: begin
                    tick  <= '0;
                    abusi <= rel_target;
                end
                CMD_ADV: begin
                    if (tick == TICK_LAST) begin
                        tick  <= '0;
                        abusi <= pc_next_seq;
                        step  <= 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    // Hold: a paused advance keeps its tick count.
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : scoreboard bench for pc_sequencer with a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam int ADDR_W = 8;
    localparam int TPS    = 2;
    localparam int DEPTH  = 4;
    localparam int OFFS_W = 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              ldpc = 0, load = 0, rel = 0, call = 0, ret = 0, clr_err = 0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [OFFS_W-1:0] rel_offs  = '0;
    logic [ADDR_W-1:0] abusi;
    logic              step, stk_empty, stk_full, err_ovf, err_unf;

    pc_sequencer #(
        .ADDR_W         (ADDR_W),
        .TICKS_PER_STEP (TPS),
        .STACK_DEPTH    (DEPTH),
        .RESET_ADDR     (0),
        .OFFS_W         (OFFS_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .ldpc      (ldpc),
        .load      (load),
        .rel       (rel),
        .call      (call),
        .ret       (ret),
        .clr_err   (clr_err),
        .load_addr (load_addr),
        .rel_offs  (rel_offs),
        .abusi     (abusi),
        .step      (step),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    initial forever #5 sys_clk = ~sys_clk;

    typedef struct {
        int pc;
        bit step;
        bit empty;
        bit full;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: PC as an integer, stack as a queue of integers.
    int m_pc, m_tick, m_stk[$];
    bit m_ovf, m_unf, m_step;

    function automatic void model_reset();
        m_pc = 0; m_tick = 0; m_stk.delete();
        m_ovf = 0; m_unf = 0; m_step = 0;
    endfunction

    function automatic void check(string name, exp_t e);
        tests++;
        if (abusi !== ADDR_W'(e.pc) || step !== e.step || stk_empty !== e.empty ||
            stk_full !== e.full || err_ovf !== e.ovf || err_unf !== e.unf) begin
            fails++;
            $display("FAIL %s t=%0t: got pc=%02h step=%b empty=%b full=%b ovf=%b unf=%b, want pc=%02h step=%b empty=%b full=%b ovf=%b unf=%b",
                     name, $time, abusi, step, stk_empty, stk_full, err_ovf, err_unf,
                     e.pc[7:0], e.step, e.empty, e.full, e.ovf, e.unf);
        end
    endfunction

    function automatic exp_t model_state();
        exp_t e;
        e.pc = m_pc; e.step = m_step; e.empty = (m_stk.size() == 0);
        e.full = (m_stk.size() == DEPTH); e.ovf = m_ovf; e.unf = m_unf;
        return e;
    endfunction

    // Monitor: every cycle the DUT presents a new state, compare it to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", e);
            end
        end
    end

    task automatic drive(input bit r, input bit c, input bit l, input bit rl,
                         input bit a, input bit ce, input int addr, input int offs);
        int so;
        @(negedge sys_clk);
        ret = r; call = c; load = l; rel = rl; ldpc = a; clr_err = ce;
        load_addr = ADDR_W'(addr); rel_offs = OFFS_W'(offs);
        m_step = 0;
        if (ce) begin m_ovf = 0; m_unf = 0; end
        if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_unf = 1;
            m_tick = 0;
        end else if (c) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back((m_pc + 1) % 256);
                m_pc = addr & 255;
            end else m_ovf = 1;
            m_tick = 0;
        end else if (l) begin
            m_pc = addr & 255; m_tick = 0;
        end else if (rl) begin
            so   = (offs & 255) >= 128 ? (offs & 255) - 256 : (offs & 255);
            m_pc = (m_pc + so) & 255; m_tick = 0;
        end else if (a) begin
            m_tick++;
            if (m_tick == TPS) begin
                m_tick = 0; m_pc = (m_pc + 1) & 255; m_step = 1;
            end
        end
        exp_q.push_back(model_state());
    endtask

    // Async reset asserted mid-cycle; outputs must drop to reset values at once.
    task automatic mid_reset();
        exp_t e;
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        ret = 0; call = 0; load = 0; rel = 0; ldpc = 0; clr_err = 0;
        #1;
        model_reset();
        e = model_state();
        check("async_reset", e);
        @(negedge sys_clk);
        sys_rst = 1'b1;
    endtask

    initial begin
        exp_t e;
        model_reset();
        #1;
        e = model_state();
        check("reset_state", e);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;

        // Timed advance: pc 0,1,1,2,2,3 with step after each increment.
        repeat (6) drive(0, 0, 0, 0, 1, 0, 0, 0);

        // Wrap 0xFF -> 0x00, then relative -2 from 0x01.
        drive(0, 0, 1, 0, 0, 0, 8'hFF, 0);
        repeat (2) drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 8'h01, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 8'hFE);
        drive(0, 0, 0, 1, 0, 0, 0, 8'h7F);

        // Nested calls and returns.
        drive(0, 0, 1, 0, 0, 0, 8'h10, 0);
        drive(0, 1, 0, 0, 0, 0, 8'h40, 0);
        drive(0, 1, 0, 0, 0, 0, 8'h80, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // Overflow on the fifth call, clear, drain, underflow.
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0, 16 * (i + 1), 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);

        // Priority: ret beats call/load/ldpc; load beats rel.
        drive(0, 0, 1, 0, 0, 0, 8'h21, 0);
        drive(0, 1, 0, 0, 0, 0, 8'h50, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 1, 0, 8'h99, 0);
        drive(0, 0, 1, 1, 0, 0, 8'h33, 8'h05);
        repeat (2) drive(0, 0, 0, 0, 1, 0, 0, 0);

        // Pause and resume the tick count, then reset mid-run.
        drive(0, 0, 1, 0, 0, 0, 8'h60, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 8'h70, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        mid_reset();
        repeat (3) drive(0, 0, 0, 0, 1, 0, 0, 0);

        // Randomized mix with independent strobes to exercise priority.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 6,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        @(posedge sys_clk);
        #5;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
